// File: rtl/l2_rr_arbiter.sv
// Shares the single L2 port between the i-cache and d-cache, one transaction at a time.
// Optional per-side grant counters are compiled in with ARB_GRANT_CNT_EN.
module l2_rr_arbiter #(
  parameter int D_PRIORITY = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  i_arb_mem_address,
  input  logic         i_arb_mem_read,
  output logic [127:0] i_arb_mem_rdata,
  output logic         i_arb_mem_resp,
  input  logic [15:0]  d_arb_mem_address,
  input  logic         d_arb_mem_read,
  input  logic         d_arb_mem_write,
  input  logic [127:0] d_arb_mem_wdata,
  output logic [127:0] d_arb_mem_rdata,
  output logic         d_arb_mem_resp,
  output logic [15:0]  l2arb_mem_address,
  output logic         l2arb_mem_read,
  output logic         l2arb_mem_write,
  output logic [127:0] l2arb_mem_wdata,
  input  logic [127:0] l2arb_mem_rdata,
  input  logic         l2arb_mem_resp
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] i_grant_count,
  output logic [CNT_WIDTH-1:0] d_grant_count
`endif
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t state, state_next;
  logic   last_grant_d;
  logic   i_req, d_req;
  logic   grant_i, grant_d;

  assign i_req = i_arb_mem_read;
  assign d_req = d_arb_mem_read | d_arb_mem_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
    end else begin
      state <= state_next;
      if (grant_i)
        last_grant_d <= 1'b0;
      else if (grant_d)
        last_grant_d <= 1'b1;
    end
  end

  // Ties go to d under fixed priority, otherwise to whoever was not served last.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || (D_PRIORITY == 0 && last_grant_d))) begin
          grant_i    = 1'b1;
          state_next = I_BUSY;
        end else if (d_req) begin
          grant_d    = 1'b1;
          state_next = D_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (l2arb_mem_resp)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    i_arb_mem_resp  = 1'b0;
    d_arb_mem_resp  = 1'b0;
    i_arb_mem_rdata = '0;
    d_arb_mem_rdata = '0;
    if (state == I_BUSY && l2arb_mem_resp) begin
      i_arb_mem_resp  = 1'b1;
      i_arb_mem_rdata = l2arb_mem_rdata;
    end
    if (state == D_BUSY && l2arb_mem_resp) begin
      d_arb_mem_resp  = 1'b1;
      d_arb_mem_rdata = l2arb_mem_rdata;
    end
  end

  // L2 request registers are loaded only on a grant, so L1 changes mid-transaction are invisible.
  always_ff @(posedge clk) begin
    if (reset) begin
      l2arb_mem_address <= '0;
      l2arb_mem_read    <= 1'b0;
      l2arb_mem_write   <= 1'b0;
      l2arb_mem_wdata   <= '0;
    end else if (grant_i) begin
      l2arb_mem_address <= i_arb_mem_address;
      l2arb_mem_read    <= 1'b1;
      l2arb_mem_write   <= 1'b0;
      l2arb_mem_wdata   <= '0;
    end else if (grant_d) begin
      l2arb_mem_address <= d_arb_mem_address;
      l2arb_mem_read    <= d_arb_mem_read & ~d_arb_mem_write;
      l2arb_mem_write   <= d_arb_mem_write;
      l2arb_mem_wdata   <= d_arb_mem_wdata;
    end else if (state != IDLE && l2arb_mem_resp) begin
      l2arb_mem_read    <= 1'b0;
      l2arb_mem_write   <= 1'b0;
    end
  end

`ifdef ARB_GRANT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      i_grant_count <= '0;
      d_grant_count <= '0;
    end else begin
      if (grant_i && i_grant_count != {CNT_WIDTH{1'b1}})
        i_grant_count <= i_grant_count + 1'b1;
      if (grant_d && d_grant_count != {CNT_WIDTH{1'b1}})
        d_grant_count <= d_grant_count + 1'b1;
    end
  end
`else
  // CNT_WIDTH only shapes the optional counters; nothing to build without them.
  if (CNT_WIDTH < 1) begin : g_cnt_width_unused
  end
`endif

endmodule
